// File: rtl/fib_lookup_ctrl.sv
// FIB binary-search-tree lookup controller: walks node table from the root,
// comparing the latched key against each node's data word, one node read per hop.
module fib_lookup_ctrl #(
   parameter int unsigned WORD_SIZE    = 16,
   parameter int unsigned POINTER_SIZE = 16,
   parameter int unsigned HOP_WIDTH    = 8,
   parameter int unsigned MAX_HOPS     = 32
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic [POINTER_SIZE-1:0] root_pointer_in,
   input  logic                    root_valid_in,
   input  logic                    req_valid_in,
   input  logic [WORD_SIZE-1:0]    req_key_in,
   output logic                    req_ready_out,
   output logic                    mem_rd_en_out,
   output logic [POINTER_SIZE-1:0] mem_addr_out,
   input  logic [WORD_SIZE-1:0]    node_data_word_in,
   input  logic                    node_valid_bit_in,
   input  logic [POINTER_SIZE-1:0] node_left_pointer_in,
   input  logic [POINTER_SIZE-1:0] node_right_pointer_in,
   input  logic                    node_left_pointer_valid_bit_in,
   input  logic                    node_right_pointer_valid_bit_in,
   output logic                    resp_valid_out,
   input  logic                    resp_ready_in,
   output logic                    resp_found_out,
   output logic                    resp_error_out,
   output logic [POINTER_SIZE-1:0] resp_pointer_out,
   output logic [HOP_WIDTH-1:0]    resp_hops_out,
   output logic                    busy_out
);

   localparam logic [HOP_WIDTH-1:0] MaxHopsW = HOP_WIDTH'(MAX_HOPS);

   typedef enum logic [1:0] {StIdle, StRead, StEval, StResp} state_e;

   state_e                  state_q, state_d;
   logic [WORD_SIZE-1:0]    key_q, key_d;
   logic [POINTER_SIZE-1:0] cur_ptr_q, cur_ptr_d;
   logic [POINTER_SIZE-1:0] resp_ptr_q, resp_ptr_d;
   logic [HOP_WIDTH-1:0]    hops_q, hops_d;
   logic                    found_q, found_d;
   logic                    error_q, error_d;

   logic                    go_left;
   logic                    nxt_valid;
   logic [POINTER_SIZE-1:0] nxt_ptr;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= StIdle;
         key_q      <= '0;
         cur_ptr_q  <= '0;
         resp_ptr_q <= '0;
         hops_q     <= '0;
         found_q    <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         cur_ptr_q  <= cur_ptr_d;
         resp_ptr_q <= resp_ptr_d;
         hops_q     <= hops_d;
         found_q    <= found_d;
         error_q    <= error_d;
      end
   end

   // Child selection only matters when the key differs from the node word.
   assign go_left   = key_q < node_data_word_in;
   assign nxt_valid = go_left ? node_left_pointer_valid_bit_in : node_right_pointer_valid_bit_in;
   assign nxt_ptr   = go_left ? node_left_pointer_in : node_right_pointer_in;

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      cur_ptr_d  = cur_ptr_q;
      resp_ptr_d = resp_ptr_q;
      hops_d     = hops_q;
      found_d    = found_q;
      error_d    = error_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid_in) begin
               key_d      = req_key_in;
               hops_d     = '0;
               found_d    = 1'b0;
               error_d    = 1'b0;
               resp_ptr_d = '0;
               if (root_valid_in) begin
                  cur_ptr_d = root_pointer_in;
                  state_d   = StRead;
               end else begin
                  state_d = StResp;
               end
            end
         end
         StRead: begin
            hops_d  = hops_q + HOP_WIDTH'(1);
            state_d = StEval;
         end
         StEval: begin
            state_d = StResp;
            if (!node_valid_bit_in) begin
               found_d = 1'b0;
            end else if (key_q == node_data_word_in) begin
               found_d    = 1'b1;
               resp_ptr_d = cur_ptr_q;
            end else if (nxt_valid) begin
               if (hops_q == MaxHopsW) begin
                  error_d = 1'b1;
               end else begin
                  cur_ptr_d = nxt_ptr;
                  state_d   = StRead;
               end
            end
         end
         StResp: begin
            if (resp_ready_in) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready_out    = state_q == StIdle;
      mem_rd_en_out    = state_q == StRead;
      resp_valid_out   = state_q == StResp;
      busy_out         = state_q != StIdle;
      mem_addr_out     = cur_ptr_q;
      resp_found_out   = found_q;
      resp_error_out   = error_q;
      resp_pointer_out = resp_ptr_q;
      resp_hops_out    = hops_q;
   end

endmodule

// File: doc/fib_lookup_ctrl.md
# fib_lookup_ctrl

Lookup controller for the FIB binary-search tree: accepts one key at a time and walks the tree of FIB nodes stored in a node table. At each node it compares the key against the node's data word and follows the left or right pointer. It returns hit/miss, the matching node address and the hop count. It sits between the packet-processing front end (requester) and the node storage read port.

## Interface

- WORD_SIZE, 16, key / node data word width
- POINTER_SIZE, 16, node address width
- HOP_WIDTH, 8, width of hop counter
- MAX_HOPS, 32, maximum node reads per lookup (1..2^HOP_WIDTH-1)

Ports (clock and reset first; reset is asynchronous, active-low):

- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- root_pointer_in  input  POINTER_SIZE  address of tree root (static during lookup)
- root_valid_in  input  1  1'b1 = tree non-empty
- req_valid_in  input  1  lookup request valid
- req_key_in  input  WORD_SIZE  key to search
- req_ready_out  output  1  controller can accept request
- mem_rd_en_out  output  1  node read strobe
- mem_addr_out  output  POINTER_SIZE  node address to read
- node_data_word_in  input  WORD_SIZE  node data word, cycle after mem_rd_en_out
- node_valid_bit_in  input  1  node valid
- node_left_pointer_in  input  POINTER_SIZE  left child
- node_right_pointer_in  input  POINTER_SIZE  right child
- node_left_pointer_valid_bit_in  input  1  left child valid
- node_right_pointer_valid_bit_in  input  1  right child valid
- resp_valid_out  output  1  response valid
- resp_ready_in  input  1  requester accepts response
- resp_found_out  output  1  key matched
- resp_error_out  output  1  hop limit exceeded
- resp_pointer_out  output  POINTER_SIZE  address of matched node, 0 on miss/error
- resp_hops_out  output  HOP_WIDTH  node reads performed
- busy_out  output  1  lookup in progress (state != IDLE)

## Operation

- FSM states: IDLE, READ, EVAL, RESP.
- IDLE: req_ready_out=1. When req_valid_in is high, latch the key and clear hops.
  - If root_valid_in=1, load cur_ptr=root_pointer_in and go to READ.
  - Otherwise go directly to RESP as a miss (hops=0).
- READ: assert mem_rd_en_out=1 with mem_addr_out=cur_ptr, increment hops, go to EVAL.
- EVAL: node_* inputs are valid this cycle; evaluate in priority order:
  - node_valid_bit_in=0 → miss.
  - key == data_word → hit; resp_pointer=cur_ptr.
  - key < data_word (unsigned): if left valid, cur_ptr=left and continue; else miss.
  - key > data_word: same rule using right.
  - Continue with hops==MAX_HOPS → error (found=0, error=1), no further read.
  - Continue otherwise → READ.
- RESP: hold all resp_* stable with resp_valid_out=1 until resp_ready_in=1; then go to IDLE.
- mem_rd_en_out is high only in READ. mem_addr_out holds cur_ptr in all states.
- req_ready_out is high only in IDLE; there is no request queueing.

## Timing

- Reset (asynchronous assert, synchronous release): state=IDLE.
  - All outputs 0 except req_ready_out=1.
  - Latched key, cur_ptr and hops cleared.
- Reset mid-lookup aborts immediately. Read data arriving after reset is ignored.
- Request accepted on edge T0. READ in cycle T0+1, EVAL in T0+2.
- Each hop costs 2 cycles. resp_valid_out rises at T0+1+2·N for N node reads.
  - Root hit: resp_valid_out at T0+3.
  - Empty tree: resp_valid_out at T0+1, hops=0.
- Response handshake completes on the edge where resp_valid_out & resp_ready_in. IDLE follows, so the earliest next accept is one cycle later.
- Minimum throughput: one lookup per 2N+2 cycles.
- Hop counter never wraps; MAX_HOPS bounds it.
- Comparison is full-width unsigned. Pointers are used verbatim with no arithmetic.

## Test plan

- Root node data=0x0050, valid, key=0x0050 → resp_valid at T0+3, found=1, pointer=root, hops=1, error=0.
- Three-level tree: root 0x0050 (L→0x0002), node 0x0002 data 0x0030 (R→0x0007), node 0x0007 data 0x0040; key 0x0040 → found=1, pointer=0x0007, hops=3, resp_valid at T0+7; mem_addr sequence root, 0x0002, 0x0007.
- Key 0x0010 at root 0x0050 with left pointer invalid → found=0, pointer=0, hops=1. Separately, root_valid_in=0 → miss at T0+1 with hops=0 and no mem_rd_en_out pulse.
- Node whose right pointer is itself with MAX_HOPS=4, key greater than data → exactly 4 reads, found=0, error=1, hops=4.
- Hold resp_ready_in=0 for 5 cycles after a hit → resp_* stable and req_ready_out=0 throughout; accept on release, then IDLE. A new request is accepted only the cycle after.
- Assert rst_n_in low during EVAL of a second hop → all outputs reset asynchronously. After release, a fresh root-hit lookup completes normally in 3 cycles.
